// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating-counter branch predictor table with sweep clear (optional stats: BHT_STATS_EN)
module branch_history_table #(
  parameter int size    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] pc_f,
  output logic            predict_taken,
  input  logic            upd_valid,
  input  logic [size-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_predicted,
  input  logic            flush_req,
  output logic            busy,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] sweep_idx;
  logic [1:0]       ctr_q [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_cur;
  logic [1:0]       wr_next;
  logic             upd_accept;
  logic             sweep_last;

  // Word-aligned PCs: drop the two byte-offset bits, no tag, aliasing allowed
  assign rd_idx = pc_f[IDX_W+1:2];
  assign wr_idx = upd_pc[IDX_W+1:2];

  // PC bits outside the index field and the byte offset do not affect the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[1:0], pc_f[size-1:IDX_W+2],
                            upd_pc[1:0], upd_pc[size-1:IDX_W+2], upd_predicted};

  // Next state, update acceptance, busy and the gated prediction
  always_comb begin
    state_d       = state_q;
    upd_accept    = 1'b0;
    sweep_last    = 1'b0;
    busy          = 1'b0;
    predict_taken = 1'b0;
    case (state_q)
      IDLE: begin
        upd_accept    = upd_valid;
        predict_taken = ctr_q[rd_idx][1];
        if (flush_req) begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        busy       = 1'b1;
        sweep_last = (sweep_idx == IDX_W'(ENTRIES - 1));
        if (sweep_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating increment/decrement of the addressed counter
  always_comb begin
    wr_cur  = ctr_q[wr_idx];
    wr_next = wr_cur;
    if (upd_taken) begin
      if (wr_cur != 2'b11) begin
        wr_next = wr_cur + 2'b01;
      end
    end else begin
      if (wr_cur != 2'b00) begin
        wr_next = wr_cur - 2'b01;
      end
    end
  end

  // FSM state and sweep pointer; pointer idles at 0 so a new sweep starts at entry 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sweep_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SWEEP) begin
        sweep_idx <= sweep_idx + 1'b1;
      end else begin
        sweep_idx <= '0;
      end
    end
  end

  // Counter array: sweep writes weakly-not-taken, otherwise accepted updates train
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (state_q == SWEEP) begin
      ctr_q[sweep_idx] <= 2'b01;
    end else if (upd_accept) begin
      ctr_q[wr_idx] <= wr_next;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] branch_q;
  logic [31:0] mispredict_q;

  // Saturating statistics; only reset clears them, a flush leaves them intact
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_q     <= '0;
      mispredict_q <= '0;
    end else if (upd_accept) begin
      if (branch_q != 32'hFFFF_FFFF) begin
        branch_q <= branch_q + 32'd1;
      end
      if ((upd_taken != upd_predicted) && (mispredict_q != 32'hFFFF_FFFF)) begin
        mispredict_q <= mispredict_q + 32'd1;
      end
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispredict_q;
`else
  assign branch_count     = 32'd0;
  assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// tb/tb_branch_history_table.sv - directed self-checking bench for branch_history_table
module tb_branch_history_table;

  logic        clk;
  logic        reset;
  logic [31:0] pc_f;
  logic        predict_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_predicted;
  logic        flush_req;
  logic        busy;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_br      = 0;
  int exp_mis     = 0;
  int cyc;

  branch_history_table #(
    .size   (32),
    .ENTRIES(64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_f            (pc_f),
    .predict_taken   (predict_taken),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_predicted   (upd_predicted),
    .flush_req       (flush_req),
    .busy            (busy),
    .branch_count    (branch_count),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    pc_f = pc;
    #1;
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic p);
    upd_valid     = 1'b1;
    upd_pc        = pc;
    upd_taken     = t;
    upd_predicted = p;
    step();
    upd_valid = 1'b0;
    exp_br++;
    if (t != p) exp_mis++;
  endtask

  task automatic check_stats(input string tag);
`ifdef BHT_STATS_EN
    check({tag, "_branch"}, branch_count, exp_br);
    check({tag, "_mispred"}, mispredict_count, exp_mis);
`else
    check({tag, "_branch"}, branch_count, 32'd0);
    check({tag, "_mispred"}, mispredict_count, 32'd0);
`endif
  endtask

  initial begin
    reset         = 1'b0;
    pc_f          = '0;
    upd_valid     = 1'b0;
    upd_pc        = '0;
    upd_taken     = 1'b0;
    upd_predicted = 1'b0;
    flush_req     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pred", predict_taken, 0);
    check("rst_branch", branch_count, 0);
    check("rst_mispred", mispredict_count, 0);
    reset = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      look(i * 4);
      check("init_pred", predict_taken, 0);
    end
    check_stats("init");

    // Training and saturation on PC 0x40 (index 16)
    update(32'h40, 1'b1, 1'b0); look(32'h40); check("train_t1", predict_taken, 1);
    update(32'h40, 1'b1, 1'b1); look(32'h40); check("train_t2", predict_taken, 1);
    update(32'h40, 1'b1, 1'b1); look(32'h40); check("train_t3", predict_taken, 1);
    update(32'h40, 1'b0, 1'b1); look(32'h40); check("train_nt1", predict_taken, 1);
    update(32'h40, 1'b0, 1'b1); look(32'h40); check("train_nt2", predict_taken, 0);

    // Aliasing: 0x140 shares index 16 with 0x40
    update(32'h140, 1'b1, 1'b0); look(32'h40);  check("alias_a", predict_taken, 1);
    update(32'h40, 1'b0, 1'b1);  look(32'h140); check("alias_b", predict_taken, 0);

    // Same-cycle lookup and update: no bypass
    look(32'h100);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_predicted = 1'b0;
    #1;
    check("nobypass_same", predict_taken, 0);
    step();
    upd_valid = 1'b0;
    exp_br++; exp_mis++;
    check("nobypass_next", predict_taken, 1);
    check_stats("pre_flush");

    // Train entries 1..10 to strongly taken
    for (int k = 1; k <= 10; k++) begin
      update(k * 4, 1'b1, 1'b1);
      update(k * 4, 1'b1, 1'b1);
    end
    look(32'h4);  check("trained_1", predict_taken, 1);
    look(32'h28); check("trained_10", predict_taken, 1);

    // Flush with a simultaneous accepted update to entry 11
    flush_req = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h2C; upd_taken = 1'b1; upd_predicted = 1'b1;
    step();
    flush_req = 1'b0;
    upd_valid = 1'b0;
    exp_br++;
    check("flush_busy", busy, 1);
    look(32'h4);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      check("sweep_pred", predict_taken, 0);
      if (cyc == 20) begin
        upd_valid = 1'b1; upd_pc = 32'h4; upd_taken = 1'b1; upd_predicted = 1'b0;
      end
      if (cyc == 30) flush_req = 1'b1;
      step();
      upd_valid = 1'b0;
      flush_req = 1'b0;
    end
    check("sweep_len", cyc, 64);
    check_stats("post_flush");
    for (int i = 0; i < 64; i++) begin
      look(i * 4);
      check("swept_pred", predict_taken, 0);
    end
    update(32'h4, 1'b1, 1'b1);  look(32'h4);  check("swept_is_01_e1", predict_taken, 1);
    update(32'h2C, 1'b1, 1'b1); look(32'h2C); check("swept_is_01_e11", predict_taken, 1);
    check_stats("after_retrain");

    // Reset mid-sweep
    update(32'hFC, 1'b1, 1'b1);
    update(32'hFC, 1'b1, 1'b1);
    look(32'hFC); check("e63_trained", predict_taken, 1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (10) step();
    check("midsweep_busy", busy, 1);
    reset = 1'b0;
    #1;
    exp_br = 0; exp_mis = 0;
    check("arst_busy", busy, 0);
    check("arst_branch", branch_count, 0);
    check("arst_mispred", mispredict_count, 0);
    check("arst_pred", predict_taken, 0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_busy", busy, 0);
    look(32'hFC); check("post_rst_e63", predict_taken, 0);
    update(32'hFC, 1'b1, 1'b0); look(32'hFC); check("post_rst_e63_01", predict_taken, 1);
    check_stats("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Dynamic branch predictor table for the fetch stage: a direct-mapped array of 2-bit saturating counters indexed by PC. Fetch reads a taken/not-taken prediction combinationally. The execute stage writes back resolved branch outcomes through the update port. This is the resolution-side counterpart of the fetch-side static jump decode, and it replaces the constant "B-type taken" assumption with learned state. A sequential sweep engine clears the whole table on request.

## Interface
- `size`, 32, PC width in bits.
- `ENTRIES`, 64, number of counters; must be a power of two, 4..1024. `IDX_W = log2(ENTRIES)`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_f`  in  size  fetch PC to predict for.
- `predict_taken`  out  1  prediction for `pc_f`; 1 means taken.
- `upd_valid`  in  1  a resolved conditional branch is presented this cycle.
- `upd_pc`  in  size  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome of the branch.
- `upd_predicted`  in  1  prediction that fetch used for this branch.
- `flush_req`  in  1  single-cycle request to clear the table.
- `busy`  out  1  sweep in progress.
- `branch_count`  out  32  number of accepted updates (statistics).
- `mispredict_count`  out  32  number of accepted updates with `upd_taken != upd_predicted`.

## Operation
- Index is `pc[IDX_W+1:2]` for both the lookup port and the update port. There is no tag, so aliasing between PCs is allowed.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- `predict_taken` equals MSB of `counter[idx(pc_f)]` when in IDLE. It is forced to 0 when `busy`.
- An update is accepted when `upd_valid=1` and the FSM is in IDLE.
  - `upd_taken=1`: the counter increments, saturating at 11.
  - `upd_taken=0`: the counter decrements, saturating at 00.
- Updates presented while `busy` are dropped. They change neither the table nor the statistics.
- FSM states:
  - IDLE → SWEEP on `flush_req=1`. The sweep index is loaded with 0.
  - SWEEP: writes 01 to `counter[sweep_idx]` each cycle, then increments `sweep_idx`.
  - SWEEP → IDLE after writing entry `ENTRIES-1`.
  - `flush_req` asserted during SWEEP is ignored; it does not restart the sweep.
- Reset value of every counter is 01.

## Timing
- Lookup is combinational from `pc_f` to `predict_taken`; there is no registered output.
- An update written at edge N is visible on `predict_taken` from cycle N+1.
- Same-cycle lookup and update to the same index: `predict_taken` shows the pre-update value. There is no bypass.
- Flush: `flush_req` sampled high at edge N.
  - `busy=1` from cycle N+1 through cycle N+ENTRIES.
  - `busy=0` from cycle N+ENTRIES+1.
  - The sweep takes exactly ENTRIES cycles.
- Simultaneous `flush_req` and `upd_valid` in IDLE: the update is applied at that edge, then the sweep starts and overwrites it.
- Reset values, all asynchronous:
  - All counters 01.
  - FSM IDLE, `sweep_idx` 0, `busy` 0.
  - `predict_taken` 0.
  - `branch_count` 0, `mispredict_count` 0.
- Reset asserted mid-sweep: the sweep aborts immediately, the state returns to IDLE, and all counters go to 01.

## Configuration
- `BHT_STATS_EN` defined:
  - `branch_count` increments once per accepted update.
  - `mispredict_count` increments when an accepted update has `upd_taken != upd_predicted`.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
  - Neither counter is cleared by `flush_req`; only `reset` clears them.
- `BHT_STATS_EN` undefined:
  - Ports remain present; both outputs are tied to 0 and no counter flops are inferred.
  - Table and prediction behaviour are unchanged.

## Test plan
- Reset, then sweep `pc_f` over all 64 indices: `predict_taken=0` everywhere. Stats read 0.
- Three updates to PC 0x0000_0040 with `upd_taken=1`: prediction is 1 after the first update (01→10), and the counter saturates at 11. Then one not-taken update gives 10, so the prediction stays 1. A second not-taken update gives 01, so the prediction is 0.
- PC 0x0000_0040 and PC 0x0000_0140 alias at index 16 (ENTRIES=64): training one changes the prediction of the other.
- Same-cycle lookup and update to PC 0x100 with the counter at 01 and `upd_taken=1`: `predict_taken=0` in that cycle and 1 in the next.
- Train 10 entries to 11, then pulse `flush_req`:
  - `busy` is high for exactly 64 cycles.
  - `predict_taken=0` throughout the sweep.
  - An update issued mid-sweep is dropped and `branch_count` is unchanged.
  - After the sweep, all entries read 01.
- With `BHT_STATS_EN`: 5 accepted updates, 2 with `upd_predicted != upd_taken` → `branch_count=5`, `mispredict_count=2`. Assert `reset` low mid-sweep → both read 0, `busy=0`.
